// File: rtl/wbgen2_pkg.sv
// Shared definitions for the wbgen2 RAM/Wishbone bridge slice.
//   t_wb_state  : bridge FSM state encoding
//   C_BYTE_W    : bits per byte select lane
//   C_CNT_W     : width of the read-latency counter (covers latencies 1..2)
//   f_in_range  : word address < implemented RAM size
package wbgen2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE     = 2'd1,
    ST_READ_WAIT = 2'd2,
    ST_ACK       = 2'd3
  } t_wb_state;

  localparam int unsigned C_BYTE_W = 8;
  localparam int unsigned C_CNT_W  = 2;

  function automatic logic f_in_range(input logic [31:0] adr, input int unsigned size);
    return (adr < size);
  endfunction

endpackage

// File: rtl/wbgen2_dpssram.sv
// Dual-port synchronous RAM with per-byte write enables and a configurable
// read latency of 1 or 2 clocks. Both ports share one clock.
//   clk_i                      : clock
//   addr_x_i / data_x_i        : word address / write data (x = a, b)
//   bwsel_x_i                  : byte write selects
//   rd_x_i / wr_x_i            : read / write strobes
//   data_x_o                   : read data, valid g_read_latency clocks after rd_x_i
// Accesses at or beyond g_size are ignored (writes) or return zero (reads).
// On a same-address, same-clock write from both ports, port A wins.
module wbgen2_dpssram
  import wbgen2_pkg::*;
#(
  parameter int g_data_width   = 32,
  parameter int g_size         = 1024,
  parameter int g_addr_width   = 10,
  parameter int g_read_latency = 1
) (
  input  logic                      clk_i,
  input  logic [g_addr_width-1:0]   addr_a_i,
  input  logic [g_data_width-1:0]   data_a_i,
  input  logic [g_data_width/8-1:0] bwsel_a_i,
  input  logic                      rd_a_i,
  input  logic                      wr_a_i,
  output logic [g_data_width-1:0]   data_a_o,
  input  logic [g_addr_width-1:0]   addr_b_i,
  input  logic [g_data_width-1:0]   data_b_i,
  input  logic [g_data_width/8-1:0] bwsel_b_i,
  input  logic                      rd_b_i,
  input  logic                      wr_b_i,
  output logic [g_data_width-1:0]   data_b_o
);

  localparam int C_SEL_W = g_data_width / 8;

  logic [g_data_width-1:0] r_mem [0:g_size-1];
  logic [g_data_width-1:0] r_qa1, r_qa2, r_qb1, r_qb2;
  logic                    w_a_ok, w_b_ok;

  assign w_a_ok = f_in_range(32'(addr_a_i), g_size);
  assign w_b_ok = f_in_range(32'(addr_b_i), g_size);

  always_ff @(posedge clk_i) begin
    // Port B first so that a colliding port A write lands last.
    if (wr_b_i && w_b_ok) begin
      for (int b = 0; b < C_SEL_W; b++) begin
        if (bwsel_b_i[b]) r_mem[addr_b_i][b*C_BYTE_W +: C_BYTE_W] <= data_b_i[b*C_BYTE_W +: C_BYTE_W];
      end
    end
    if (wr_a_i && w_a_ok) begin
      for (int b = 0; b < C_SEL_W; b++) begin
        if (bwsel_a_i[b]) r_mem[addr_a_i][b*C_BYTE_W +: C_BYTE_W] <= data_a_i[b*C_BYTE_W +: C_BYTE_W];
      end
    end
    if (rd_a_i) r_qa1 <= w_a_ok ? r_mem[addr_a_i] : '0;
    if (rd_b_i) r_qb1 <= w_b_ok ? r_mem[addr_b_i] : '0;
    r_qa2 <= r_qa1;
    r_qb2 <= r_qb1;
  end

  assign data_a_o = (g_read_latency == 2) ? r_qa2 : r_qa1;
  assign data_b_o = (g_read_latency == 2) ? r_qb2 : r_qb1;

endmodule

// File: rtl/wbgen2_ram_wb_bridge.sv
// Wishbone slave to single-port synchronous RAM bridge (one transfer at a time).
//   clk_sys_i, rst_n_i          : clock, asynchronous active-low reset
//   wb_cyc_i/stb_i/we_i         : Wishbone cycle, strobe, write enable
//   wb_adr_i/sel_i/dat_i        : word address, byte selects, write data
//   wb_dat_o/ack_o/err_o/stall_o: read data, acknowledge, error, busy
//   ram_addr_o/data_o/bwsel_o   : registered RAM address, write data, byte selects
//   ram_rd_o/ram_wr_o           : single-clock RAM read / write strobes
//   ram_data_i                  : RAM read data, g_read_latency clocks after ram_rd_o
// Timing from the request clock: write ack and error one clock later; read ack
// g_read_latency+2 clocks later, in the same clock wb_dat_o shows the new data.
module wbgen2_ram_wb_bridge
  import wbgen2_pkg::*;
#(
  parameter int g_data_width   = 32,
  parameter int g_addr_width   = 10,
  parameter int g_size         = 1024,
  parameter int g_read_latency = 1
) (
  input  logic                      clk_sys_i,
  input  logic                      rst_n_i,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  input  logic                      wb_we_i,
  input  logic [g_addr_width-1:0]   wb_adr_i,
  input  logic [g_data_width/8-1:0] wb_sel_i,
  input  logic [g_data_width-1:0]   wb_dat_i,
  output logic [g_data_width-1:0]   wb_dat_o,
  output logic                      wb_ack_o,
  output logic                      wb_err_o,
  output logic                      wb_stall_o,
  output logic [g_addr_width-1:0]   ram_addr_o,
  output logic [g_data_width-1:0]   ram_data_o,
  output logic [g_data_width/8-1:0] ram_bwsel_o,
  output logic                      ram_rd_o,
  output logic                      ram_wr_o,
  input  logic [g_data_width-1:0]   ram_data_i
);

  localparam int C_SEL_W = g_data_width / 8;
  // Counter value in READ_WAIT on the edge where RAM data is valid.
  localparam logic [C_CNT_W-1:0] C_CAP_CNT = C_CNT_W'(g_read_latency);

  t_wb_state               r_state, w_state_nxt;
  logic [C_CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic                    r_ack, w_ack_nxt;
  logic                    r_err, w_err_nxt;
  logic                    r_rd, w_rd_nxt;
  logic                    r_wr, w_wr_nxt;
  logic [g_data_width-1:0] r_dat, w_dat_nxt;
  logic [g_addr_width-1:0] r_addr, w_addr_nxt;
  logic [g_data_width-1:0] r_wdata, w_wdata_nxt;
  logic [C_SEL_W-1:0]      r_bwsel, w_bwsel_nxt;
  logic                    w_req, w_adr_ok;

  assign w_req    = wb_cyc_i & wb_stb_i;
  assign w_adr_ok = f_in_range(32'(wb_adr_i), g_size);

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_dat   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_bwsel <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_rd    <= w_rd_nxt;
      r_wr    <= w_wr_nxt;
      r_dat   <= w_dat_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_bwsel <= w_bwsel_nxt;
    end
  end

  // All strobes default low, so ack/err/rd/wr are one-clock pulses by construction.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_rd_nxt    = 1'b0;
    w_wr_nxt    = 1'b0;
    w_dat_nxt   = r_dat;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_bwsel_nxt = r_bwsel;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (!w_adr_ok) begin
            // Error answered from ACK so stall stays high while err is shown.
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_ACK;
          end else if (wb_we_i) begin
            w_addr_nxt  = wb_adr_i;
            w_wdata_nxt = wb_dat_i;
            w_bwsel_nxt = wb_sel_i;
            w_wr_nxt    = 1'b1;
            w_ack_nxt   = 1'b1;
            w_state_nxt = ST_WRITE;
          end else begin
            w_addr_nxt  = wb_adr_i;
            w_bwsel_nxt = '1;
            w_rd_nxt    = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_READ_WAIT;
          end
        end
      end
      ST_WRITE: begin
        w_state_nxt = ST_IDLE;
      end
      ST_READ_WAIT: begin
        if (!wb_cyc_i) begin
          // Master gave up: leave wb_dat_o untouched and never acknowledge.
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == C_CAP_CNT) begin
          w_dat_nxt   = ram_data_i;
          w_ack_nxt   = 1'b1;
          w_state_nxt = ST_ACK;
        end else begin
          w_cnt_nxt = r_cnt + C_CNT_W'(1);
        end
      end
      ST_ACK: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign wb_dat_o    = r_dat;
  assign wb_ack_o    = r_ack;
  assign wb_err_o    = r_err;
  assign wb_stall_o  = (r_state != ST_IDLE);
  assign ram_addr_o  = r_addr;
  assign ram_data_o  = r_wdata;
  assign ram_bwsel_o = r_bwsel;
  assign ram_rd_o    = r_rd;
  assign ram_wr_o    = r_wr;

endmodule

// File: tb/tb_wbgen2_ram_wb_bridge.sv
module tb_wbgen2_ram_wb_bridge;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int SW = DW / 8;
  localparam int NV = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Index 0: g_size=1000, latency 1.  Index 1: g_size=1024, latency 2.
  logic          rst_n [2];
  logic          cyc [2], stb [2], we [2];
  logic [AW-1:0] adr [2];
  logic [SW-1:0] sel [2];
  logic [DW-1:0] wdat [2], rdat [2];
  logic          ack [2], err [2], stall [2];
  logic [AW-1:0] ram_addr [2];
  logic [DW-1:0] ram_wdata [2], ram_rdata [2];
  logic [SW-1:0] ram_bwsel [2];
  logic          ram_rd [2], ram_wr [2];
  logic [AW-1:0] b_addr [2];
  logic          b_rd [2];
  logic [DW-1:0] b_q [2];
  logic          b_wr = 1'b0;
  logic [DW-1:0] b_wdat = '0;
  logic [SW-1:0] b_sel = '0;

  wbgen2_ram_wb_bridge #(.g_data_width(DW), .g_addr_width(AW), .g_size(1000), .g_read_latency(1)) u_dut0 (
    .clk_sys_i(clk), .rst_n_i(rst_n[0]), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
    .wb_adr_i(adr[0]), .wb_sel_i(sel[0]), .wb_dat_i(wdat[0]), .wb_dat_o(rdat[0]), .wb_ack_o(ack[0]),
    .wb_err_o(err[0]), .wb_stall_o(stall[0]), .ram_addr_o(ram_addr[0]), .ram_data_o(ram_wdata[0]),
    .ram_bwsel_o(ram_bwsel[0]), .ram_rd_o(ram_rd[0]), .ram_wr_o(ram_wr[0]), .ram_data_i(ram_rdata[0]));

  wbgen2_dpssram #(.g_data_width(DW), .g_size(1000), .g_addr_width(AW), .g_read_latency(1)) u_ram0 (
    .clk_i(clk), .addr_a_i(ram_addr[0]), .data_a_i(ram_wdata[0]), .bwsel_a_i(ram_bwsel[0]),
    .rd_a_i(ram_rd[0]), .wr_a_i(ram_wr[0]), .data_a_o(ram_rdata[0]),
    .addr_b_i(b_addr[0]), .data_b_i(b_wdat), .bwsel_b_i(b_sel), .rd_b_i(b_rd[0]), .wr_b_i(b_wr),
    .data_b_o(b_q[0]));

  wbgen2_ram_wb_bridge #(.g_data_width(DW), .g_addr_width(AW), .g_size(1024), .g_read_latency(2)) u_dut1 (
    .clk_sys_i(clk), .rst_n_i(rst_n[1]), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
    .wb_adr_i(adr[1]), .wb_sel_i(sel[1]), .wb_dat_i(wdat[1]), .wb_dat_o(rdat[1]), .wb_ack_o(ack[1]),
    .wb_err_o(err[1]), .wb_stall_o(stall[1]), .ram_addr_o(ram_addr[1]), .ram_data_o(ram_wdata[1]),
    .ram_bwsel_o(ram_bwsel[1]), .ram_rd_o(ram_rd[1]), .ram_wr_o(ram_wr[1]), .ram_data_i(ram_rdata[1]));

  wbgen2_dpssram #(.g_data_width(DW), .g_size(1024), .g_addr_width(AW), .g_read_latency(2)) u_ram1 (
    .clk_i(clk), .addr_a_i(ram_addr[1]), .data_a_i(ram_wdata[1]), .bwsel_a_i(ram_bwsel[1]),
    .rd_a_i(ram_rd[1]), .wr_a_i(ram_wr[1]), .data_a_o(ram_rdata[1]),
    .addr_b_i(b_addr[1]), .data_b_i(b_wdat), .bwsel_b_i(b_sel), .rd_b_i(b_rd[1]), .wr_b_i(b_wr),
    .data_b_o(b_q[1]));

  typedef struct {
    int            d;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] dat;
    logic [SW-1:0] s;
    logic          e_ack;
    logic          e_err;
    int            e_lat;
    logic [DW-1:0] e_rdat;
    logic [DW-1:0] e_bd;
  } vec_t;

  vec_t vt [NV];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One Wishbone transfer; lat is the clock (1 = first clock after the request
  // clock) in which ack or err appeared, -1 if none within the budget.
  task automatic xfer(input int d, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] dd,
                      input logic [SW-1:0] s, output int lat, output logic g_ack, output logic g_err,
                      output int n_wr, output int n_rd, output logic [SW-1:0] bw, output logic pulse_ok);
    lat = -1; g_ack = 1'b0; g_err = 1'b0; n_wr = 0; n_rd = 0; bw = '0; pulse_ok = 1'b1;
    @(posedge clk); #1;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; wdat[d] = dd; sel[d] = s;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (ram_wr[d]) begin n_wr++; bw = ram_bwsel[d]; end
      if (ram_rd[d]) begin n_rd++; bw = ram_bwsel[d]; end
      if (ack[d] || err[d]) begin
        lat = k; g_ack = ack[d]; g_err = err[d];
        break;
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    @(posedge clk); #1;
    if (ack[d] || err[d] || ram_wr[d] || ram_rd[d]) pulse_ok = 1'b0;
  endtask

  task automatic bd_read(input int d, input logic [AW-1:0] a, output logic [DW-1:0] q);
    @(posedge clk); #1;
    b_addr[d] = a; b_rd[d] = 1'b1;
    @(posedge clk); #1;
    b_rd[d] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    q = b_q[d];
  endtask

  task automatic check_zero_outputs(input int d, input string tag);
    check({tag, "_ctl"}, {59'd0, ack[d], err[d], stall[d], ram_rd[d], ram_wr[d]}, 64'd0);
    check({tag, "_dat"}, 64'(rdat[d]), 64'd0);
    check({tag, "_ram"}, {22'd0, ram_addr[d], ram_wdata[d]}, 64'd0);
    check({tag, "_bwsel"}, 64'(ram_bwsel[d]), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            lat, n_wr, n_rd, seen;
    logic          g_ack, g_err, pulse_ok;
    logic [SW-1:0] bw;
    logic [DW-1:0] q;

    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b1; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      adr[d] = '0; sel[d] = '0; wdat[d] = '0; b_addr[d] = '0; b_rd[d] = 1'b0;
    end

    //              d  w     adr      dat           sel   ack   err   lat rdat          backdoor
    vt[0]  = '{0, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 1, 32'h00000000, 32'hDEADBEEF};
    vt[1]  = '{0, 1'b0, 10'h005, 32'h00000000, 4'hF, 1'b1, 1'b0, 3, 32'hDEADBEEF, 32'h0};
    vt[2]  = '{0, 1'b1, 10'h005, 32'h0000AB00, 4'h2, 1'b1, 1'b0, 1, 32'hDEADBEEF, 32'hDEADABEF};
    vt[3]  = '{0, 1'b0, 10'h005, 32'h00000000, 4'hF, 1'b1, 1'b0, 3, 32'hDEADABEF, 32'h0};
    vt[4]  = '{0, 1'b1, 10'h3E8, 32'h55555555, 4'hF, 1'b0, 1'b1, 1, 32'hDEADABEF, 32'h0};
    vt[5]  = '{0, 1'b0, 10'h3E8, 32'h00000000, 4'hF, 1'b0, 1'b1, 1, 32'hDEADABEF, 32'h0};
    vt[6]  = '{0, 1'b1, 10'h3E7, 32'h12345678, 4'hF, 1'b1, 1'b0, 1, 32'hDEADABEF, 32'h12345678};
    vt[7]  = '{0, 1'b0, 10'h3E7, 32'h00000000, 4'hF, 1'b1, 1'b0, 3, 32'h12345678, 32'h0};
    vt[8]  = '{0, 1'b1, 10'h000, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0, 1, 32'h12345678, 32'hCAFEF00D};
    vt[9]  = '{0, 1'b0, 10'h000, 32'h00000000, 4'hF, 1'b1, 1'b0, 3, 32'hCAFEF00D, 32'h0};
    vt[10] = '{1, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 1, 32'h00000000, 32'hDEADBEEF};
    vt[11] = '{1, 1'b0, 10'h005, 32'h00000000, 4'hF, 1'b1, 1'b0, 4, 32'hDEADBEEF, 32'h0};
    vt[12] = '{1, 1'b1, 10'h3E8, 32'h11223344, 4'hF, 1'b1, 1'b0, 1, 32'hDEADBEEF, 32'h11223344};
    vt[13] = '{1, 1'b0, 10'h3E8, 32'h00000000, 4'hF, 1'b1, 1'b0, 4, 32'h11223344, 32'h0};
    vt[14] = '{1, 1'b1, 10'h3FF, 32'h0BADC0DE, 4'hF, 1'b1, 1'b0, 1, 32'h11223344, 32'h0BADC0DE};
    vt[15] = '{1, 1'b0, 10'h3FF, 32'h00000000, 4'hF, 1'b1, 1'b0, 4, 32'h0BADC0DE, 32'h0};
    vt[16] = '{1, 1'b1, 10'h005, 32'h01000000, 4'h8, 1'b1, 1'b0, 1, 32'h0BADC0DE, 32'h01ADBEEF};
    vt[17] = '{1, 1'b0, 10'h005, 32'h00000000, 4'hF, 1'b1, 1'b0, 4, 32'h01ADBEEF, 32'h0};

    // Reset state
    #2;
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    #20;
    check_zero_outputs(0, "reset0");
    check_zero_outputs(1, "reset1");
    @(posedge clk); #1;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    // Table-driven transfers
    for (int i = 0; i < NV; i++) begin
      xfer(vt[i].d, vt[i].w, vt[i].a, vt[i].dat, vt[i].s, lat, g_ack, g_err, n_wr, n_rd, bw, pulse_ok);
      check($sformatf("v%0d_ack", i), 64'(g_ack), 64'(vt[i].e_ack));
      check($sformatf("v%0d_err", i), 64'(g_err), 64'(vt[i].e_err));
      check($sformatf("v%0d_lat", i), 64'(lat), 64'(vt[i].e_lat));
      check($sformatf("v%0d_rdat", i), 64'(rdat[vt[i].d]), 64'(vt[i].e_rdat));
      check($sformatf("v%0d_nwr", i), 64'(n_wr), 64'(vt[i].w && vt[i].e_ack));
      check($sformatf("v%0d_nrd", i), 64'(n_rd), 64'(!vt[i].w && vt[i].e_ack));
      check($sformatf("v%0d_bwsel", i), 64'(bw), !vt[i].e_ack ? 64'd0 : (vt[i].w ? 64'(vt[i].s) : 64'hF));
      check($sformatf("v%0d_pulse", i), 64'(pulse_ok), 64'd1);
      if (vt[i].w && vt[i].e_ack) begin
        bd_read(vt[i].d, vt[i].a, q);
        check($sformatf("v%0d_backdoor", i), 64'(q), 64'(vt[i].e_bd));
      end
    end

    // Abort: drop wb_cyc_i while the read waits for RAM data
    @(posedge clk); #1;
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 10'h005;
    @(posedge clk); #1;
    check("abort_in_wait", 64'(stall[0]), 64'd1);
    cyc[0] = 1'b0; stb[0] = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (ack[0] || err[0]) seen++;
    end
    check("abort_no_ack", 64'(seen), 64'd0);
    check("abort_idle", 64'(stall[0]), 64'd0);
    check("abort_dat_hold", 64'(rdat[0]), 64'hCAFEF00D);
    xfer(0, 1'b0, 10'h005, '0, 4'hF, lat, g_ack, g_err, n_wr, n_rd, bw, pulse_ok);
    check("after_abort_ack", 64'(g_ack), 64'd1);
    check("after_abort_lat", 64'(lat), 64'd3);
    check("after_abort_rdat", 64'(rdat[0]), 64'hDEADABEF);

    // Reset asserted while a latency-2 read is waiting
    @(posedge clk); #1;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 10'h3FF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_mid_busy", 64'(stall[1]), 64'd1);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    rst_n[1] = 1'b0;
    #2;
    check_zero_outputs(1, "rst_mid");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (ack[1] || err[1]) seen++;
    end
    check("rst_no_ack", 64'(seen), 64'd0);
    check("rst_dat_zero", 64'(rdat[1]), 64'd0);
    xfer(1, 1'b0, 10'h005, '0, 4'hF, lat, g_ack, g_err, n_wr, n_rd, bw, pulse_ok);
    check("after_rst_lat", 64'(lat), 64'd4);
    check("after_rst_rdat", 64'(rdat[1]), 64'h01ADBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
